fibo_checker: RTL and testbench

//  Stream consumer for the Fibonacci term generator: accepts terms over a valid/ready

---
 rtl/fibo_pkg.sv | 16 +
 rtl/fibo_checker.sv | 127 ++++++++++++
 tb/tb_fibo_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci stream checker and its generator-side bench.
package fibo_pkg;

   typedef enum logic [2:0] {
      SEED0 = 3'd0,
      SEED1 = 3'd1,
      TRACK = 3'd2,
      ERR   = 3'd3,
      OVF   = 3'd4
   } fibo_state_t;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_CNT_W  = 16;
   localparam int DEFAULT_LOCK_N = 2;

endpackage

// File: rtl/fibo_checker.sv
// Consumes a Fibonacci term stream, seeds from the first two terms and checks
// every later term against the sum of the previous two; stalls on error or overflow.
module fibo_checker
   import fibo_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int CNT_W  = DEFAULT_CNT_W,
   parameter int LOCK_N = DEFAULT_LOCK_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             term_ok,
   output logic             term_bad,
   output logic             locked,
   output logic [CNT_W-1:0] match_count,
   output logic [WIDTH-1:0] expected,
   output logic [WIDTH-1:0] err_data,
   output logic             overflow,
   output fibo_state_t      dbg_state
);

   // Handshake: a term transfers on a rising edge where in_valid & in_ready are both
   // high; in_ready depends on the state register only, never on in_valid or clear.

   fibo_state_t      state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ok_q, ok_d, bad_q, bad_d, ovf_q, ovf_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   look;
   logic             accept;

   assign in_ready = (state_q == SEED0) || (state_q == SEED1) || (state_q == TRACK);
   assign accept   = in_valid && in_ready;

   // sum is the next expected term; look pre-computes the term after the incoming one
   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign look = {1'b0, (state_q == SEED1) ? a_q : b_q} + {1'b0, in_data};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      ok_d    = 1'b0;
      bad_d   = 1'b0;
      if (clear) begin
         state_d = SEED0;
         a_d     = '0;
         b_d     = '0;
         err_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else if (accept) begin
         unique case (state_q)
            SEED0: begin
               a_d     = in_data;
               state_d = SEED1;
            end
            SEED1: begin
               b_d = in_data;
               if (look[WIDTH]) begin
                  ovf_d   = 1'b1;
                  state_d = OVF;
               end else begin
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (in_data == sum[WIDTH-1:0]) begin
                  ok_d  = 1'b1;
                  a_d   = b_q;
                  b_d   = in_data;
                  cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                  if (look[WIDTH]) begin
                     ovf_d   = 1'b1;
                     state_d = OVF;
                  end
               end else begin
                  bad_d   = 1'b1;
                  err_d   = in_data;
                  state_d = ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEED0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         ok_q    <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         ok_q    <= ok_d;
         bad_q   <= bad_d;
      end
   end

   assign term_ok     = ok_q;
   assign term_bad    = bad_q;
   assign match_count = cnt_q;
   assign err_data    = err_q;
   assign overflow    = ovf_q;
   assign locked      = (state_q == TRACK) && (cnt_q >= CNT_W'(LOCK_N));
   assign expected    = (state_q == TRACK) ? sum[WIDTH-1:0] : '0;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fibo_checker.sv
// Randomized bench for fibo_checker against a term-history reference model.
module tb_fibo_checker;
   import fibo_pkg::*;

   localparam longint MAXV    = 64'h0000_0000_FFFF_FFFF;
   localparam int     CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, term_ok, term_bad, locked, overflow;
   logic [15:0] match_count;
   logic [31:0] expected, err_data;
   fibo_state_t dbg_state;

   int errors = 0;
   int checks = 0;
   int bad_seen = 0;

   fibo_checker #(.WIDTH(32), .CNT_W(16), .LOCK_N(2)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .term_ok(term_ok), .term_bad(term_bad), .locked(locked),
      .match_count(match_count), .expected(expected), .err_data(err_data),
      .overflow(overflow), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: history of accepted terms ----------------
   longint      hist[$];
   int          m_cnt;
   logic        m_err, m_ovf, m_ok, m_bad;
   logic [31:0] m_errd;

   function automatic fibo_state_t m_state();
      if (m_err) return ERR;
      if (m_ovf) return OVF;
      if (hist.size() == 0) return SEED0;
      if (hist.size() == 1) return SEED1;
      return TRACK;
   endfunction

   function automatic logic m_ready();
      return (m_state() == SEED0) || (m_state() == SEED1) || (m_state() == TRACK);
   endfunction

   function automatic longint m_next();
      int n = hist.size();
      return hist[n-1] + hist[n-2];
   endfunction

   task automatic model_reset();
      hist.delete();
      m_cnt = 0; m_err = 0; m_ovf = 0; m_ok = 0; m_bad = 0; m_errd = '0;
   endtask

   task automatic model_accept(input logic [31:0] d);
      longint dl = longint'({32'b0, d});
      int n = hist.size();
      case (m_state())
         SEED0: hist.push_back(dl);
         SEED1: begin
            if (hist[0] + dl > MAXV) m_ovf = 1;
            hist.push_back(dl);
         end
         TRACK: begin
            if (dl == m_next()) begin
               m_ok = 1;
               if (m_cnt < CNT_MAX) m_cnt++;
               if (hist[n-1] + dl > MAXV) m_ovf = 1;
               hist.push_back(dl);
               void'(hist.pop_front());
            end else begin
               m_bad = 1; m_err = 1; m_errd = d;
            end
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      fibo_state_t s = m_state();
      check_eq("in_ready", 64'(in_ready), 64'(m_ready()));
      check_eq("term_ok", 64'(term_ok), 64'(m_ok));
      check_eq("term_bad", 64'(term_bad), 64'(m_bad));
      check_eq("match_count", 64'(match_count), 64'(m_cnt));
      check_eq("err_data", 64'(err_data), 64'(m_errd));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("locked", 64'(locked), 64'((s == TRACK) && (m_cnt >= 2)));
      check_eq("expected", 64'(expected), (s == TRACK) ? 64'(m_next() & MAXV) : 64'd0);
      check_eq("state", 64'(dbg_state), 64'(s));
   endtask

   // ---------------- drivers ----------------
   // One clock: drive at negedge, DUT samples at posedge, outputs checked at next negedge.
   task automatic drive(input logic v, input logic [31:0] d, input logic clr, output logic acc);
      in_valid = v; in_data = d; clear = clr;
      m_ok = 0; m_bad = 0;
      acc = 1'b0;
      if (clr) model_reset();
      else if (v && m_ready()) begin
         model_accept(d);
         acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (term_bad) bad_seen++;
      check_all();
   endtask

   task automatic do_clear();
      logic acc;
      drive(1'b0, '0, 1'b1, acc);
   endtask

   // Sends a Fibonacci-like stream from seeds s0,s1; term index bad_idx gets +delta.
   // Each term is offered until accepted; stops once the model stops accepting.
   task automatic feed_fib(input longint s0, input longint s1, input int n, input bit rnd,
                           input int bad_idx, input logic [31:0] delta);
      longint p = s0, q = s1, t;
      int sent = 0, budget = 8 * n + 20;
      logic acc, v;
      logic [31:0] d;
      while (sent < n && budget > 0 && m_ready()) begin
         t = (sent == 0) ? s0 : (sent == 1) ? s1 : p + q;
         d = 32'(t);
         if (sent == bad_idx) d = d + delta;
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         drive(v, d, 1'b0, acc);
         if (acc) begin
            if (sent >= 2) begin p = q; q = t; end
            sent++;
         end
         budget--;
      end
      drive(1'b0, '0, 1'b0, acc);
      check_eq("feed_budget", 64'(budget > 0), 64'd1);
   endtask

   logic        acc;
   logic [15:0] cont_cnt;
   logic [31:0] cont_exp;

   initial begin
      model_reset();
      // reset state
      @(negedge clk); @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();

      // directed 1,2,3,5,8,13
      feed_fib(1, 2, 6, 0, -1, 0);
      check_eq("dir_count4", 64'(match_count), 64'd4);
      check_eq("dir_exp21", 64'(expected), 64'd21);
      check_eq("dir_locked", 64'(locked), 64'd1);

      // async reset mid-TRACK
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // mismatch 1,2,3,6 then clear
      drive(1, 1, 0, acc); drive(1, 2, 0, acc); drive(1, 3, 0, acc); drive(1, 6, 0, acc);
      check_eq("bad_err6", 64'(err_data), 64'd6);
      check_eq("bad_ready0", 64'(in_ready), 64'd0);
      check_eq("bad_count1", 64'(match_count), 64'd1);
      drive(1, 5, 0, acc);
      do_clear();
      check_eq("clr_state", 64'(dbg_state), 64'(SEED0));
      check_eq("clr_err0", 64'(err_data), 64'd0);

      // generator run to overflow stall
      bad_seen = 0;
      feed_fib(1, 2, 100, 0, -1, 0);
      drive(1, 32'h1234, 0, acc);
      check_eq("gen_count44", 64'(match_count), 64'd44);
      check_eq("gen_ovf", 64'(overflow), 64'd1);
      check_eq("gen_ready0", 64'(in_ready), 64'd0);
      check_eq("gen_nobad", 64'(bad_seen), 64'd0);

      // continuous vs randomly-throttled feed from seeds 3,5
      do_clear();
      feed_fib(3, 5, 20, 0, -1, 0);
      cont_cnt = match_count; cont_exp = expected;
      do_clear();
      feed_fib(3, 5, 20, 1, -1, 0);
      check_eq("rnd_count", 64'(match_count), 64'(cont_cnt));
      check_eq("rnd_exp", 64'(expected), 64'(cont_exp));

      // clear with a same-cycle valid term
      drive(1, 32'(m_next()), 1, acc);
      check_eq("clrv_state", 64'(dbg_state), 64'(SEED0));
      check_eq("clrv_nopulse", 64'(term_ok), 64'd0);

      // random seeds with optional corruption, plus an overflow at SEED1
      for (int r = 0; r < 8; r++) begin
         do_clear();
         feed_fib(longint'($urandom_range(0, 1000)), longint'($urandom_range(0, 1000)),
                  $urandom_range(3, 14), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? int'($urandom_range(2, 12)) : -1,
                  32'($urandom_range(1, 50)));
      end
      do_clear();
      feed_fib(64'hF000_0000, 64'h2000_0000, 3, 0, -1, 0);
      check_eq("seed_ovf", 64'(overflow), 64'd1);

      // 0,0 then 70000 zeros: counter saturation
      do_clear();
      drive(1, 0, 0, acc); drive(1, 0, 0, acc);
      for (int i = 0; i < 70000; i++) drive(1, 0, 0, acc);
      check_eq("sat_count", 64'(match_count), 64'd65535);
      check_eq("sat_locked", 64'(locked), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
